// File: rtl/voice_pkg.sv
// Shared types and constants for the spoken-digit classifier.
//   voice_state_t : classifier FSM encoding (exposed in STATE[31:30])
//   rx_state_t    : UART receiver sequencing
//   TMPL / SEG    : digit templates and 7-segment codes {g,f,e,d,c,b,a}
//   calc_div      : clocks per UART bit, rounded to nearest
package voice_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_MATCH = 2'd2,
      ST_DONE  = 2'd3
   } voice_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PAR,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   // Template for digit d is 16 + 24*d
   localparam logic [7:0] TMPL [0:9] = '{
      8'd16, 8'd40, 8'd64, 8'd88, 8'd112,
      8'd136, 8'd160, 8'd184, 8'd208, 8'd232
   };

   localparam logic [6:0] SEG [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   function automatic int calc_div(input int clk_freq, input int baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/voice_rx_if.sv
// Received-byte channel between the UART receiver and the classifier top.
//   rx_byte    : last good byte (valid while byte_valid is high)
//   byte_valid : one-cycle pulse per good frame
//   frame_err  : one-cycle pulse per bad frame (stop or parity failure)
interface voice_rx_if;
   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       frame_err;

   modport master (output rx_byte, output byte_valid, output frame_err);
   modport slave  (input  rx_byte, input  byte_valid, input  frame_err);
endinterface

// File: rtl/voice_uart_rx.sv
// UART receiver: 2-FF synchronizer, mid-bit sampling, even parity and
// stop-bit check.
//   CLK, RST_N : clock, async active-low reset
//   i_rxd      : serial input, idle high
//   rx         : byte / byte_valid / frame_err pulses to the top
module voice_uart_rx
   import voice_pkg::*;
#(
   parameter int CLK_FREQ   = 3684000,
   parameter int BAUD_RATE  = 115200,
   parameter int PARITY_BIT = 0
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       i_rxd,
   voice_rx_if.master rx
);

   localparam int          DIV     = calc_div(CLK_FREQ, BAUD_RATE);
   localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

   logic        r_sync1;
   logic        r_sync2;
   rx_state_t   r_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_par_ok;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync1       <= 1'b1;
         r_sync2       <= 1'b1;
         r_state       <= RX_IDLE;
         r_cnt         <= '0;
         r_bit         <= '0;
         r_shift       <= '0;
         r_par_ok      <= 1'b1;
         rx.rx_byte    <= '0;
         rx.byte_valid <= 1'b0;
         rx.frame_err  <= 1'b0;
      end else begin
         r_sync1       <= i_rxd;
         r_sync2       <= r_sync1;
         rx.byte_valid <= 1'b0;
         rx.frame_err  <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               if (!r_sync2) begin
                  r_cnt   <= HALF_M1;
                  r_state <= RX_START;
               end
            end
            RX_START: begin
               if (r_cnt != 0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else if (r_sync2) begin
                  r_state <= RX_IDLE;          // glitch, not a start bit
               end else begin
                  r_cnt    <= FULL_M1;
                  r_bit    <= '0;
                  r_par_ok <= 1'b1;
                  r_state  <= RX_DATA;
               end
            end
            RX_DATA: begin
               if (r_cnt != 0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  r_shift <= {r_sync2, r_shift[7:1]};
                  r_cnt   <= FULL_M1;
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd7)
                     r_state <= (PARITY_BIT != 0) ? RX_PAR : RX_STOP;
               end
            end
            RX_PAR: begin
               if (r_cnt != 0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else begin
                  r_par_ok <= (r_sync2 == ^r_shift);
                  r_cnt    <= FULL_M1;
                  r_state  <= RX_STOP;
               end
            end
            RX_STOP: begin
               if (r_cnt != 0) begin
                  r_cnt <= r_cnt - 16'd1;
               end else if (r_sync2 && r_par_ok) begin
                  rx.rx_byte    <= r_shift;
                  rx.byte_valid <= 1'b1;
                  r_state       <= RX_IDLE;
               end else begin
                  rx.frame_err <= 1'b1;
                  r_state      <= RX_BREAK;
               end
            end
            // A low stop bit leaves the line low for the rest of the bit;
            // wait for it to go high so that tail is not taken as a new start.
            RX_BREAK: begin
               if (r_sync2)
                  r_state <= RX_IDLE;
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/voice_recognition.sv
// Spoken-digit classifier: UART samples fill a 16-entry circular buffer,
// VLD averages the buffer and picks the nearest digit template, `send`
// echoes the last received byte.
//   CLK, RST_N       : clock, async active-low reset
//   UART_RXD/TXD     : serial in / out, idle high
//   send, VLD        : echo request (rising edge), classify pulse
//   BUSY, FRAME_ERR  : transmitter active, last frame bad
//   result           : 7-segment code of last digit
//   STATE            : {fsm, digit, wr_ptr, 2'b0, sum, last_byte}
//
// state    | meaning
// ST_IDLE  | wait for VLD
// ST_ACCUM | add buffer[0..15] into sum, one entry per cycle
// ST_MATCH | compare avg against templates 0..9, keep closest
// ST_DONE  | register digit and 7-segment result
module voice_recognition
   import voice_pkg::*;
#(
   parameter int CLK_FREQ   = 3684000,
   parameter int BAUD_RATE  = 115200,
   parameter int PARITY_BIT = 0
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        UART_RXD,
   input  logic        send,
   input  logic        VLD,
   output logic        UART_TXD,
   output logic        BUSY,
   output logic        FRAME_ERR,
   output logic [6:0]  result,
   output logic [31:0] STATE
);

   localparam int          DIV     = calc_div(CLK_FREQ, BAUD_RATE);
   localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
   localparam logic [3:0]  TX_LAST = (PARITY_BIT != 0) ? 4'd10 : 4'd9;

   voice_rx_if u_rx_if ();

   voice_uart_rx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .PARITY_BIT (PARITY_BIT)
   ) u_rx (
      .CLK   (CLK),
      .RST_N (RST_N),
      .i_rxd (UART_RXD),
      .rx    (u_rx_if.master)
   );

   // ---------------- sample buffer ----------------
   logic [7:0] r_buf [16];
   logic [3:0] r_wr_ptr;
   logic [7:0] r_last_byte;
   logic       r_frame_err;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < 16; i++) r_buf[i] <= '0;
         r_wr_ptr    <= '0;
         r_last_byte <= '0;
         r_frame_err <= 1'b0;
      end else if (u_rx_if.byte_valid) begin
         r_buf[r_wr_ptr] <= u_rx_if.rx_byte;
         r_wr_ptr        <= r_wr_ptr + 4'd1;
         r_last_byte     <= u_rx_if.rx_byte;
         r_frame_err     <= 1'b0;
      end else if (u_rx_if.frame_err) begin
         r_frame_err <= 1'b1;
      end
   end

   // ---------------- transmitter ----------------
   logic        r_send_d;
   logic        r_busy;
   logic        r_txd;
   logic [9:0]  r_tx_sh;
   logic [15:0] r_tx_cnt;
   logic [3:0]  r_tx_left;
   logic [9:0]  w_tx_bits;

   // Bits following the start bit; a spare trailing 1 in 8N1 is never sent.
   assign w_tx_bits = (PARITY_BIT != 0) ? {1'b1, ^r_last_byte, r_last_byte}
                                        : {2'b11, r_last_byte};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_send_d  <= 1'b0;
         r_busy    <= 1'b0;
         r_txd     <= 1'b1;
         r_tx_sh   <= '0;
         r_tx_cnt  <= '0;
         r_tx_left <= '0;
      end else begin
         r_send_d <= send;
         if (!r_busy) begin
            if (send && !r_send_d) begin
               r_busy    <= 1'b1;
               r_txd     <= 1'b0;
               r_tx_sh   <= w_tx_bits;
               r_tx_cnt  <= FULL_M1;
               r_tx_left <= TX_LAST;
            end
         end else if (r_tx_cnt != 0) begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
         end else if (r_tx_left == 0) begin
            r_busy <= 1'b0;
            r_txd  <= 1'b1;
         end else begin
            r_txd     <= r_tx_sh[0];
            r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
            r_tx_cnt  <= FULL_M1;
            r_tx_left <= r_tx_left - 4'd1;
         end
      end
   end

   // ---------------- classifier ----------------
   voice_state_t r_state;
   logic [3:0]   r_idx;
   logic [11:0]  r_sum;
   logic [7:0]   r_best;
   logic [3:0]   r_best_d;
   logic [3:0]   r_digit;
   logic [6:0]   r_result;
   logic [7:0]   w_avg;
   logic [7:0]   w_tmpl;
   logic [7:0]   w_diff;

   always_comb begin
      w_avg  = r_sum[11:4];
      w_tmpl = (r_idx < 4'd10) ? TMPL[r_idx] : 8'd0;
      w_diff = (w_avg >= w_tmpl) ? (w_avg - w_tmpl) : (w_tmpl - w_avg);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_sum    <= '0;
         r_best   <= '0;
         r_best_d <= '0;
         r_digit  <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (VLD) begin
                  r_state <= ST_ACCUM;
                  r_idx   <= '0;
                  r_sum   <= '0;
               end
            end
            ST_ACCUM: begin
               // Read live so a byte landing in a not-yet-read entry is counted.
               r_sum <= r_sum + {4'd0, r_buf[r_idx]};
               r_idx <= r_idx + 4'd1;
               if (r_idx == 4'd15)
                  r_state <= ST_MATCH;
            end
            ST_MATCH: begin
               // Strict compare keeps the lower digit on a tie.
               if (r_idx == 4'd0 || w_diff < r_best) begin
                  r_best   <= w_diff;
                  r_best_d <= r_idx;
               end
               if (r_idx == 4'd9)
                  r_state <= ST_DONE;
               else
                  r_idx <= r_idx + 4'd1;
            end
            ST_DONE: begin
               r_digit  <= r_best_d;
               r_result <= SEG[r_best_d];
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign UART_TXD  = r_txd;
   assign BUSY      = r_busy;
   assign FRAME_ERR = r_frame_err;
   assign result    = r_result;
   assign STATE     = {r_state, r_digit, r_wr_ptr, 2'b00, r_sum, r_last_byte};

endmodule

// File: tb/tb_voice_recognition.sv
module tb_voice_recognition;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        UART_RXD = 1'b1;
   logic        send = 1'b0;
   logic        VLD = 1'b0;
   logic        UART_TXD;
   logic        BUSY;
   logic        FRAME_ERR;
   logic [6:0]  result;
   logic [31:0] STATE;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   voice_recognition dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .UART_RXD  (UART_RXD),
      .send      (send),
      .VLD       (VLD),
      .UART_TXD  (UART_TXD),
      .BUSY      (BUSY),
      .FRAME_ERR (FRAME_ERR),
      .result    (result),
      .STATE     (STATE)
   );

   typedef struct packed { logic [7:0] last; logic [3:0] ptr; logic ferr; } rx_exp_t;
   typedef struct packed { logic [6:0] seg; logic [3:0] digit; logic [11:0] sum; } cls_exp_t;

   rx_exp_t    rx_q  [$];
   cls_exp_t   cls_q [$];
   logic [7:0] tx_q  [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic uart_frame(input logic [7:0] b, input logic stop);
      UART_RXD = 1'b0;
      repeat (32) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         UART_RXD = b[i];
         repeat (32) @(negedge CLK);
      end
      UART_RXD = stop;
      repeat (32) @(negedge CLK);
      UART_RXD = 1'b1;
      repeat (8) @(negedge CLK);
   endtask

   task automatic pulse_vld();
      VLD = 1'b1;
      @(negedge CLK);
      VLD = 1'b0;
   endtask

   task automatic pulse_send();
      send = 1'b1;
      repeat (2) @(negedge CLK);
      send = 1'b0;
      @(negedge CLK);
   endtask

   // RX monitor: a frame outcome shows as a wr_ptr step or FRAME_ERR rising
   initial begin
      logic [3:0] prev_ptr;
      logic       prev_ferr;
      rx_exp_t    e;
      prev_ptr  = '0;
      prev_ferr = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            prev_ptr  = '0;
            prev_ferr = 1'b0;
         end else begin
            if (STATE[25:22] != prev_ptr || (FRAME_ERR && !prev_ferr)) begin
               if (rx_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL rx_unexpected: ptr %0h ferr %0b with no frame expected",
                           STATE[25:22], FRAME_ERR);
               end else begin
                  e = rx_q.pop_front();
                  check("rx_last_byte", 32'(STATE[7:0]), 32'(e.last));
                  check("rx_wr_ptr", 32'(STATE[25:22]), 32'(e.ptr));
                  check("rx_frame_err", 32'(FRAME_ERR), 32'(e.ferr));
               end
            end
            prev_ptr  = STATE[25:22];
            prev_ferr = FRAME_ERR;
         end
      end
   end

   // Classifier monitor: compares on each DONE -> IDLE step
   initial begin
      logic [1:0] prev_st;
      int         span;
      cls_exp_t   e;
      prev_st = '0;
      span    = 0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            prev_st = '0;
            span    = 0;
         end else begin
            if (STATE[31:30] != 2'd0) begin
               span++;
            end else if (prev_st == 2'd3) begin
               if (cls_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL cls_unexpected: extra classification result %0h", result);
               end else begin
                  e = cls_q.pop_front();
                  check("cls_result", 32'(result), 32'(e.seg));
                  check("cls_digit", 32'(STATE[29:26]), 32'(e.digit));
                  check("cls_sum", 32'(STATE[19:8]), 32'(e.sum));
                  check("cls_zero_bits", 32'(STATE[21:20]), 32'd0);
                  check("cls_busy_cycles", 32'(span), 32'd27);
               end
               span = 0;
            end else begin
               span = 0;
            end
            prev_st = STATE[31:30];
         end
      end
   end

   // TX monitor: samples mid-bit and measures BUSY length
   initial begin
      int         n;
      logic [9:0] bits;
      logic [7:0] eb;
      forever begin
         @(negedge CLK);
         if (RST_N && BUSY) begin
            n    = 0;
            bits = '0;
            while (BUSY && RST_N && n < 2000) begin
               if (n % 32 == 16 && n < 320) bits[4'(n / 32)] = UART_TXD;
               n++;
               @(negedge CLK);
            end
            if (RST_N) begin
               if (tx_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL tx_unexpected: frame %0h with no send expected", bits);
               end else begin
                  eb = tx_q.pop_front();
                  check("tx_frame", 32'(bits), 32'({1'b1, eb, 1'b0}));
                  check("tx_busy_len", 32'(n), 32'd320);
               end
            end else if (tx_q.size() != 0) begin
               eb = tx_q.pop_front();   // frame aborted by reset
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(negedge CLK);
      check("rst_txd", 32'(UART_TXD), 32'd1);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_ferr", 32'(FRAME_ERR), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_state", STATE, 32'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Empty buffer: avg 0 -> digit 0; second VLD lands during MATCH
      cls_q.push_back({7'h3F, 4'd0, 12'h000});
      pulse_vld();
      repeat (20) @(negedge CLK);
      pulse_vld();
      repeat (20) @(negedge CLK);

      rx_q.push_back({8'hE7, 4'd1, 1'b0});
      uart_frame(8'hE7, 1'b1);
      for (int i = 0; i < 16; i++) begin
         rx_q.push_back({8'hE8, 4'(i + 2), 1'b0});
         uart_frame(8'hE8, 1'b1);
      end
      // All 16 entries are E8: sum E80, avg 232 -> digit 9
      cls_q.push_back({7'h6F, 4'd9, 12'hE80});
      pulse_vld();
      repeat (40) @(negedge CLK);

      rx_q.push_back({8'hE8, 4'd1, 1'b1});
      uart_frame(8'h55, 1'b0);
      rx_q.push_back({8'h12, 4'd2, 1'b0});
      uart_frame(8'h12, 1'b1);
      rx_q.push_back({8'hA5, 4'd3, 1'b0});
      uart_frame(8'hA5, 1'b1);

      tx_q.push_back(8'hA5);
      pulse_send();
      repeat (100) @(negedge CLK);
      pulse_send();                    // ignored while BUSY
      t = 0;
      while (BUSY && t < 1000) begin
         @(negedge CLK);
         t++;
      end
      check("tx_busy_drop", 32'(BUSY), 32'd0);
      repeat (5) @(negedge CLK);

      // Buffer: 14 x E8 + 12 + A5 = D67, avg 214 -> digit 8
      cls_q.push_back({7'h7F, 4'd8, 12'hD67});
      pulse_vld();
      repeat (40) @(negedge CLK);

      // Reset during start bit of TX and during ACCUM
      tx_q.push_back(8'hA5);
      pulse_send();
      pulse_vld();
      repeat (5) @(negedge CLK);
      check("pre_rst_busy", 32'(BUSY), 32'd1);
      check("pre_rst_fsm", 32'(STATE[31:30]), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("arst_txd", 32'(UART_TXD), 32'd1);
      check("arst_busy", 32'(BUSY), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      check("arst_state", STATE, 32'd0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (10) @(negedge CLK);

      check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
      check("cls_queue_drained", 32'(cls_q.size()), 32'd0);
      check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/voice_recognition.md
Name: voice_recognition

Overview:
- Single-clock spoken-digit classifier fed by a UART byte stream.
- Received bytes (audio samples) go into a 16-entry circular sample buffer.
- A VLD pulse starts classification: buffer mean is compared against ten digit templates, and the closest digit drives a 7-segment output.
- A `send` request echoes the last received byte on the UART transmit line; a 32-bit STATE word exposes internals for debug.

Parameters:
- CLK_FREQ, 3684000, clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate.
- PARITY_BIT, 0, 0 = 8N1; 1 = 8E1 (even parity bit after data, on both RX and TX).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- UART_RXD  in  1  serial input, idle high.
- send  in  1  echo request; rising edge is significant.
- VLD  in  1  start-classification pulse.
- UART_TXD  out  1  serial output, idle high.
- BUSY  out  1  transmitter active.
- FRAME_ERR  out  1  last received frame was bad.
- result  out  7  7-segment code {g,f,e,d,c,b,a}, active high.
- STATE  out  32  debug status word.

Behaviour:
- Bit period DIV = round(CLK_FREQ/BAUD_RATE); 32 at defaults.
- Reset values (asserted asynchronously):
  - UART_TXD=1, BUSY=0, FRAME_ERR=0, result=0 (blank).
  - STATE=0; all buffer entries 0; write pointer 0; FSM IDLE.
- RX:
  - UART_RXD passes through a 2-FF synchronizer.
  - A low level while RX is idle starts a frame. Re-check at DIV/2; if high, it is a glitch and RX returns to idle.
  - Then sample every DIV cycles: 8 data bits LSB first, parity if enabled, stop bit.
  - Good frame (stop=1, parity ok): write byte to buffer[wr_ptr], wr_ptr=(wr_ptr+1) mod 16 (wraps, overwriting the oldest), latch last_byte, clear FRAME_ERR.
  - Bad frame: set FRAME_ERR, discard the byte, leave wr_ptr unchanged. FRAME_ERR holds until the next good frame.
- TX:
  - A rising edge of `send` while BUSY=0 loads last_byte.
  - Output sequence: start bit 0, 8 data bits LSB first, parity if enabled, stop bit 1; each bit lasts DIV cycles.
  - BUSY goes high the cycle after the edge and drops after the stop bit completes (10*DIV cycles for 8N1).
  - A rising edge of `send` while BUSY=1 is ignored.
- Classifier FSM (codes IDLE=0, ACCUM=1, MATCH=2, DONE=3):
  - IDLE: VLD=1 sampled at edge k moves the FSM to ACCUM. VLD outside IDLE is ignored.
  - ACCUM: edges k+1..k+16 add buffer[0..15] into a 12-bit sum; unwritten entries count as 0.
  - Reaching MATCH: avg = sum>>4 (8 bit).
  - MATCH: edges k+17..k+26 compute |avg - T[d]| for d=0..9, with T[d]=16+24*d. Keep the minimum; on a tie the lower digit wins.
  - DONE: edge k+27 registers digit and result = SEG[digit]. IDLE at k+28.
- SEG table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
- A buffer write landing during ACCUM is allowed. An entry not yet read includes the new byte; an entry already read does not.
- Reset during any operation aborts RX/TX/FSM and restores all reset values.
- STATE layout:
  - [31:30] FSM code
  - [29:26] last digit
  - [25:22] wr_ptr
  - [21:20] 0
  - [19:8] running/final sum
  - [7:0] last_byte

Decomposition:
- Package voice_pkg:
  - FSM state enum
  - template constant array T[0..9]
  - 7-segment lookup SEG[0..9]
  - DIV computation function
- One sub-module, voice_uart_rx: synchronizer, bit timing, parity/stop check. Outputs byte, byte_valid pulse, frame_err.
- TX, buffer, and FSM live in the top level.

Test Plan:
- Reset, then frame 0xE7 (8N1, 32 clk/bit) -> STATE[7:0]=E7, STATE[25:22]=1, FRAME_ERR=0.
- 16 frames of 0xE8, then VLD pulse -> 28 cycles later result=6F (digit 9), STATE[29:26]=9, STATE[19:8]=E80.
- From reset, VLD only -> avg 0, result=3F. A second VLD during MATCH is ignored (single DONE).
- Frame with stop bit 0 -> FRAME_ERR=1, wr_ptr unchanged. A following good 0x12 -> FRAME_ERR=0, STATE[7:0]=12.
- Receive 0xA5, pulse send -> UART_TXD: 0, then 1,0,1,0,0,1,0,1, then 1, each 32 cycles; BUSY high 320 cycles. Send during BUSY -> no restart.
- Assert RST_N=0 mid-ACCUM and mid-TX -> UART_TXD=1, BUSY=0, result=0, STATE=0 immediately (asynchronous).
